// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared defaults and reset-image helper for the memories library
package mem_pkg;

  localparam int MEM_DATA_W = 8;
  localparam int MEM_ADDR_W = 8;

  // Reset image: word i holds its own index, truncated to the word width
  function automatic logic [MEM_DATA_W-1:0] init_word(input int unsigned idx);
    return idx[MEM_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/sram_sync.sv
// rtl/sram_sync.sv - single-port synchronous SRAM, write-first, registered read
module sram_sync
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] Dato_e,
  input  logic [ADDR_W-1:0] Dir,
  input  logic              WE,
  input  logic              En,
  output logic [DATA_W-1:0] Dato_s
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array is flop-based so the async reset can reload the index pattern
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(init_word(i));
      end
    end else if (En && WE) begin
      mem[Dir] <= Dato_e;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Dato_s <= '0;
    end else if (En) begin
      Dato_s <= WE ? Dato_e : mem[Dir];
    end
  end

endmodule

// File: tb/tb_sram_sync.sv
// tb/tb_sram_sync.sv - table-driven self-checking bench for sram_sync
module tb_sram_sync;

  logic       clk;
  logic       rst_n;
  logic [7:0] Dato_e;
  logic [7:0] Dir;
  logic       WE;
  logic       En;
  logic [7:0] Dato_s;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       en;
    logic       we;
    logic [7:0] dir;
    logic [7:0] din;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  sram_sync dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Dato_e(Dato_e),
    .Dir   (Dir),
    .WE    (WE),
    .En    (En),
    .Dato_s(Dato_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%02h), expected %0d (0x%02h)", name, act, act, exp, exp);
    end
  endtask

  // Drive one access, let it take the next edge, then sample just after it
  task automatic access(input logic en, input logic we, input logic [7:0] dir,
                        input logic [7:0] din, input logic [7:0] exp, input string name);
    En = en; WE = we; Dir = dir; Dato_e = din;
    @(posedge clk);
    #1;
    check(name, Dato_s, exp);
  endtask

  function automatic vec_t mk(input logic en, input logic we, input logic [7:0] dir,
                              input logic [7:0] din, input logic [7:0] exp, input string name);
    vec_t v;
    v.en = en; v.we = we; v.dir = dir; v.din = din; v.exp = exp; v.name = name;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 12; i++) vecs.push_back(mk(1, 0, 8'(i), 8'h00, 8'(i), $sformatf("reset_read_%0d", i)));
    for (int i = 0; i < 12; i++) vecs.push_back(mk(1, 1, 8'(i), 8'(220 + i), 8'(220 + i), $sformatf("write_echo_%0d", i)));
    for (int i = 0; i < 12; i++) vecs.push_back(mk(1, 0, 8'(i), 8'h00, 8'(220 + i), $sformatf("read_back_%0d", i)));
    vecs.push_back(mk(1, 0, 8'd12, 8'h00, 8'd12,  "read_untouched_12"));
    vecs.push_back(mk(0, 1, 8'd3,  8'h55, 8'd12,  "en_low_hold_a"));
    vecs.push_back(mk(0, 1, 8'd3,  8'h55, 8'd12,  "en_low_hold_b"));
    vecs.push_back(mk(1, 0, 8'd3,  8'h00, 8'd223, "en_low_no_write"));

    rst_n = 1'b0; En = 1'b0; WE = 1'b0; Dir = '0; Dato_e = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dato_s", Dato_s, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) access(vecs[k].en, vecs[k].we, vecs[k].dir, vecs[k].din, vecs[k].exp, vecs[k].name);

    // Async reset between edges must clear the output without a clock
    access(1, 1, 8'd7, 8'h99, 8'h99, "pre_reset_write");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", Dato_s, 8'h00);
    En = 1'b1; WE = 1'b1; Dir = 8'd7; Dato_e = 8'h44;
    @(posedge clk);
    #1;
    check("reset_ignores_clk", Dato_s, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    access(1, 0, 8'd7,   8'h00, 8'd7,   "post_reset_read_7");
    access(1, 0, 8'd255, 8'h00, 8'd255, "post_reset_read_255");
    access(1, 0, 8'd0,   8'h00, 8'd0,   "post_reset_read_0");

    access(1, 1, 8'd200, 8'hA5, 8'hA5, "same_addr_write");
    access(1, 0, 8'd200, 8'h00, 8'hA5, "same_addr_read");
    access(0, 0, 8'd201, 8'h00, 8'hA5, "same_addr_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
